i2s_sample_rx: RTL and testbench
================================

// Module: i2s_sample_rx
// PURPOSE
// - Upstream front end of the SOS filter chain. Deserialises one channel of a
//   standard I2S ADC stream into parallel signed samples.
// - Its data_out and sample_trig drive the filter chain's data_in and sample_trig.
// - Bit clock, word select and data come from the external ADC and are asynchronous
//   to clk. They are oversampled in the clk domain; no second clock domain exists.
// PARAMETERS
// - DATA_SIZE  24  Sample width; bits captured per slot, MSB first.
// - SLOT_BITS  32  Max sck edges per slot; a longer slot is a frame error.
// - CHANNEL    0   Captured channel: 0 = left (ws low), 1 = right (ws high).
// PORTS
// - clk          in   1          System clock; all logic on rising edge.
// - reset        in   1          Asynchronous, active-low reset.
// - i2s_sck      in   1          I2S bit clock, async to clk, f_sck <= f_clk/4.
// - i2s_ws       in   1          I2S word select, async.
// - i2s_sd       in   1          I2S serial data, async.
// - data_out     out  DATA_SIZE  Last valid sample, two's complement.
// - sample_trig  out  1          One-clk pulse: data_out just updated.
// - frame_err    out  1          One-clk pulse: malformed slot on CHANNEL was discarded.
// BEHAVIOUR
// - Reset (reset=0, async):
//   - data_out=0, sample_trig=0, frame_err=0.
//   - Shift register, bit_cnt and ws_last cleared; state=SYNC.
// - Input sampling:
//   - sck, ws and sd each pass through a 2-FF synchroniser.
//   - sck_rise = synced sck high AND previous synced sck low; one clk wide.
//   - All actions below occur only in cycles where sck_rise=1.
// - Slot framing (standard I2S, one-bit delay):
//   - A sck_rise where ws_s != ws_last is a boundary edge. It carries the previous
//     slot's LSB, which is ignored.
//   - On a boundary edge: ws_last<=ws_s, bit_cnt<=0.
//   - The MSB arrives on the next sck_rise.
// - States:
//   - SYNC: ignore data until the first boundary edge.
//     - Boundary with ws_s==CHANNEL -> CAPTURE; other boundary -> SKIP.
//   - CAPTURE: each non-boundary sck_rise does shreg<={shreg,sd_s}, bit_cnt++.
//     - When bit_cnt reaches DATA_SIZE: data_out<=shreg, sample_trig=1 for one clk,
//       then -> SKIP.
//     - Boundary edge before bit_cnt==DATA_SIZE: frame_err=1 for one clk, no data_out
//       update, then re-enter per ws_s (CAPTURE or SKIP).
//   - SKIP: count edges only. Boundary with ws_s==CHANNEL -> CAPTURE; other boundary
//     stays in SKIP.
// - Slot length: bit_cnt saturates at SLOT_BITS+1.
//   - Reaching SLOT_BITS+1 edges without a boundary -> frame_err pulse, state=SYNC.
// - Latency, raw sck rise of the DATA_SIZE-th bit to sample_trig: exactly 4 clk
//   (2 sync + 1 edge detect + 1 output register).
// - Simultaneous events:
//   - The DATA_SIZE-th bit and a boundary cannot share an edge; bits are counted
//     strictly after a boundary.
//   - sample_trig and frame_err are never high in the same cycle.
// - Between triggers:
//   - data_out holds its last value.
//   - Pulses are separated by at least one slot period; data_out is never re-issued.
// - Reset mid-slot: the partial sample is lost. After release, capture resumes only
//   after the next boundary edge.
// TESTING
// - T1 Left capture, CHANNEL=0, f_sck=f_clk/8, 32-bit slots, left=24'hA5C3F1
//   -> one sample_trig, data_out=24'hA5C3F1, 4 clk after the 24th bit's sck rise.
// - T2 Channel select, CHANNEL=1, left=24'h111111, right=24'h800001
//   -> data_out=24'h800001 only; no trig during left slots.
// - T3 Short slot: ws toggles after 16 bits on CHANNEL
//   -> frame_err pulse, no sample_trig, data_out keeps prior value.
// - T4 Long slot: 40 edges with no ws change (SLOT_BITS=32)
//   -> frame_err pulse, state SYNC; the first clean slot after a boundary captures correctly.
// - T5 Reset asserted at bit 10, released mid-slot
//   -> outputs 0 during reset; no trig for that slot; next full slot is captured.
// - T6 Back-to-back 100 frames, random data, chained into the filter chain
//   -> 100 trigs, each data_out matches the sent sample, no frame_err.

Source files
------------

// File: rtl/i2s_sample_rx.sv
// I2S receiver: oversamples sck/ws/sd in the clk domain and deserialises one
// channel's MSB-first slot into a parallel signed sample with a one-clk strobe.
module i2s_sample_rx #(
    parameter int DATA_SIZE = 24,
    parameter int SLOT_BITS = 32,
    parameter int CHANNEL   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i2s_sck,
    input  logic                 i2s_ws,
    input  logic                 i2s_sd,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 sample_trig,
    output logic                 frame_err
);

    localparam int             CNT_W    = $clog2(SLOT_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_SIZE);
    localparam logic           CH_WS    = (CHANNEL != 0);

    typedef enum logic [1:0] {
        SYNC,
        CAPTURE,
        SKIP
    } state_t;

    // {sck, ws, sd} through two synchroniser stages
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic       sck_prev_q;
    logic       rise_q;
    logic       ws_q;
    logic       sd_q;

    state_t                state_q, state_d;
    logic [DATA_SIZE-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  ws_last_q, ws_last_d;
    logic [DATA_SIZE-1:0]  data_out_q, data_out_d;
    logic                  trig_q, trig_d;
    logic                  err_q, err_d;

    logic                  boundary;
    logic [CNT_W-1:0]      cnt_inc;
    logic [DATA_SIZE-1:0]  shifted;

    // Edge detect is registered so ws/sd are realigned with the rise strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sck_prev_q <= 1'b0;
            rise_q     <= 1'b0;
            ws_q       <= 1'b0;
            sd_q       <= 1'b0;
        end else begin
            sync1_q    <= {i2s_sck, i2s_ws, i2s_sd};
            sync2_q    <= sync1_q;
            sck_prev_q <= sync2_q[2];
            rise_q     <= sync2_q[2] & ~sck_prev_q;
            ws_q       <= sync2_q[1];
            sd_q       <= sync2_q[0];
        end
    end

    assign boundary = (ws_q != ws_last_q);
    assign cnt_inc  = (bit_cnt_q == CNT_MAX) ? bit_cnt_q : bit_cnt_q + 1'b1;
    assign shifted  = {shreg_q[DATA_SIZE-2:0], sd_q};

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        ws_last_d  = ws_last_q;
        data_out_d = data_out_q;
        trig_d     = 1'b0;
        err_d      = 1'b0;

        if (rise_q) begin
            if (boundary) begin
                // This edge still carries the previous slot's LSB
                ws_last_d = ws_q;
                bit_cnt_d = '0;
                shreg_d   = '0;
                err_d     = (state_q == CAPTURE);
                state_d   = (ws_q == CH_WS) ? CAPTURE : SKIP;
            end else begin
                unique case (state_q)
                    CAPTURE: begin
                        bit_cnt_d = cnt_inc;
                        shreg_d   = shifted;
                        if (cnt_inc == CNT_DATA) begin
                            data_out_d = shifted;
                            trig_d     = 1'b1;
                            state_d    = SKIP;
                        end
                    end
                    SKIP: begin
                        bit_cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            err_d   = 1'b1;
                            state_d = SYNC;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= SYNC;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            ws_last_q  <= 1'b0;
            data_out_q <= '0;
            trig_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            ws_last_q  <= ws_last_d;
            data_out_q <= data_out_d;
            trig_q     <= trig_d;
            err_q      <= err_d;
        end
    end

    assign data_out    = data_out_q;
    assign sample_trig = trig_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_i2s_sample_rx.sv
// Scoreboard bench: a left-channel and a right-channel receiver share one I2S
// stream; expected pulses are queued per receiver before each slot is sent.
module tb_i2s_sample_rx;

    typedef struct {
        logic        is_err;
        logic [23:0] data;
        int          edge_idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sck, ws, sd;
    logic [23:0] dout0, dout1;
    logic        trig0, trig1, err0, err1;

    int          cyc = 0;
    int          tests = 0;
    int          failed = 0;
    int          rise_cyc [0:63];
    logic [23:0] last_data [0:1];
    exp_t        q0 [$];
    exp_t        q1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2s_sample_rx #(.DATA_SIZE(24), .SLOT_BITS(32), .CHANNEL(0)) u_left (
        .clk(clk), .reset(rst_n), .i2s_sck(sck), .i2s_ws(ws), .i2s_sd(sd),
        .data_out(dout0), .sample_trig(trig0), .frame_err(err0)
    );

    i2s_sample_rx #(.DATA_SIZE(24), .SLOT_BITS(32), .CHANNEL(1)) u_right (
        .clk(clk), .reset(rst_n), .i2s_sck(sck), .i2s_ws(ws), .i2s_sd(sd),
        .data_out(dout1), .sample_trig(trig1), .frame_err(err1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic handle(input int ch, input logic trig, input logic err, input logic [23:0] dout);
        exp_t e;
        bit   have = 1'b0;
        if (ch == 0 && q0.size() > 0) begin
            e = q0.pop_front();
            have = 1'b1;
        end else if (ch == 1 && q1.size() > 0) begin
            e = q1.pop_front();
            have = 1'b1;
        end
        $display("[TB] ch%0d %s data_out=%06h cycle=%0d", ch, trig ? "sample_trig" : "frame_err", dout, cyc);
        check($sformatf("ch%0d_trig_err_exclusive", ch), {31'd0, trig & err}, 32'd0);
        if (!have) begin
            check($sformatf("ch%0d_unexpected_pulse", ch), {30'd0, trig, err}, 32'd0);
        end else begin
            check($sformatf("ch%0d_pulse_kind", ch), {30'd0, trig, err}, e.is_err ? 32'd1 : 32'd2);
            check($sformatf("ch%0d_latency", ch), cyc, rise_cyc[e.edge_idx] + 4);
            check($sformatf("ch%0d_data_out", ch), {8'd0, dout}, {8'd0, e.is_err ? last_data[ch] : e.data});
            if (!e.is_err) last_data[ch] = e.data;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (trig0 || err0) handle(0, trig0, err0, dout0);
            if (trig1 || err1) handle(1, trig1, err1, dout1);
        end
    end

    task automatic exp_trig(input int ch, input logic [23:0] d);
        exp_t e;
        e.is_err = 1'b0; e.data = d; e.edge_idx = 24;
        if (ch == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic exp_err(input int ch, input int idx);
        exp_t e;
        e.is_err = 1'b1; e.data = '0; e.edge_idx = idx;
        if (ch == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Edge 0 of a slot is the ws-change edge; edges 1..24 carry the word MSB first
    task automatic send_edges(input logic w, input int first, input int last, input logic [23:0] d);
        for (int e = first; e <= last; e++) begin
            sck = 1'b0;
            ws  = w;
            sd  = (e >= 1 && e <= 24) ? d[24-e] : 1'b0;
            repeat (4) @(negedge clk);
            sck = 1'b1;
            rise_cyc[e] = cyc;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic slot(input logic w, input int n, input logic [23:0] d);
        send_edges(w, 0, n - 1, d);
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_dout0"}, {8'd0, dout0}, 32'd0);
        check({tag, "_trig0"}, {31'd0, trig0}, 32'd0);
        check({tag, "_err0"},  {31'd0, err0},  32'd0);
        check({tag, "_dout1"}, {8'd0, dout1}, 32'd0);
        check({tag, "_trig1"}, {31'd0, trig1}, 32'd0);
        check({tag, "_err1"},  {31'd0, err1},  32'd0);
    endtask

    initial begin
        logic [23:0] l_data, r_data;
        rst_n = 1'b0; sck = 1'b0; ws = 1'b0; sd = 1'b0;
        last_data[0] = '0; last_data[1] = '0;
        repeat (5) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        slot(1'b0, 32, 24'h111111);
        exp_trig(1, 24'h800001); slot(1'b1, 32, 24'h800001);
        exp_trig(0, 24'hA5C3F1); slot(1'b0, 32, 24'hA5C3F1);
        exp_trig(1, 24'h123456); slot(1'b1, 32, 24'h123456);

        // Left slot cut short after 15 data bits
        slot(1'b0, 16, 24'h5A5A5A);
        exp_err(0, 0); exp_trig(1, 24'h654321); slot(1'b1, 32, 24'h654321);

        // 40-edge slot: word is captured, then the overlong slot is flagged
        exp_trig(0, 24'h0F0F0F); exp_err(0, 33); exp_err(1, 33);
        slot(1'b0, 40, 24'h0F0F0F);
        exp_trig(1, 24'h0000FF); slot(1'b1, 32, 24'h0000FF);
        exp_trig(0, 24'hFFFFFF); slot(1'b0, 32, 24'hFFFFFF);
        exp_trig(1, 24'h222222); slot(1'b1, 32, 24'h222222);

        // Reset in the middle of a left slot
        send_edges(1'b0, 0, 9, 24'h777777);
        rst_n = 1'b0;
        last_data[0] = '0; last_data[1] = '0;
        #1;
        chk_reset("midslot_reset");
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        send_edges(1'b0, 10, 31, 24'h777777);
        exp_trig(1, 24'h333333); slot(1'b1, 32, 24'h333333);
        exp_trig(0, 24'h444444); slot(1'b0, 32, 24'h444444);

        for (int i = 0; i < 100; i++) begin
            r_data = 24'($urandom);
            l_data = 24'($urandom);
            exp_trig(1, r_data); slot(1'b1, 32, r_data);
            exp_trig(0, l_data); slot(1'b0, 32, l_data);
        end

        repeat (20) @(negedge clk);
        check("ch0_queue_drained", q0.size(), 32'd0);
        check("ch1_queue_drained", q1.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
